// File: rtl/frac_clk_div.sv
// Fractional clock divider: average output period of N + num/den input cycles.
// Each period is N or N+1 cycles long, chosen by a first-order accumulator.
// New divisor values wait in a pending set and switch in at a period boundary
// (or straight away while the divider is disabled), so clk_out never glitches.
module frac_clk_div #(
  parameter int INT_W   = 8,
  parameter int FRAC_W  = 4,
  parameter int DEF_INT = 8,
  parameter int DEF_NUM = 7,
  parameter int DEF_DEN = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              cfg_load,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] frac_num,
  input  logic [FRAC_W-1:0] frac_den,
  output logic              pulse_out,
  output logic              clk_out,
  output logic              cfg_pend
);

  localparam int CW = INT_W + 1;   // counter / period length width
  localparam int AW = FRAC_W + 1;  // accumulator width (acc + num < 2*den)

  // active and pending configuration
  logic [INT_W-1:0]  n_a, n_p;
  logic [FRAC_W-1:0] num_a, den_a, num_p, den_p;
  logic              pend;

  // period state; run marks that a period is in flight (cnt is meaningful)
  logic              run;
  logic [CW-1:0]     cnt, len;
  logic [AW-1:0]     acc;

  // sanitised capture values
  logic [INT_W-1:0]  s_int;
  logic [FRAC_W-1:0] s_num, s_den;
  logic              s_bad;

  // next-period decision
  logic              period_end, apply, start, take;
  logic [INT_W-1:0]  eff_n;
  logic [FRAC_W-1:0] eff_num, eff_den;
  logic [AW-1:0]     eff_acc, sum;
  logic [CW-1:0]     new_len, cnt_inc;

  // clamp illegal divisors: N below 2 and improper fractions fall back to integer ratio
  always_comb begin
    s_int = (div_int < INT_W'(2)) ? INT_W'(2) : div_int;
    s_bad = (frac_den == FRAC_W'(0)) || (frac_num >= frac_den);
    s_num = s_bad ? FRAC_W'(0) : frac_num;
    s_den = s_bad ? FRAC_W'(1) : frac_den;
  end

  // boundary detection and the length of the period that would start next
  always_comb begin
    period_end = run && (cnt == len - CW'(1));
    // pending config lands at a boundary, on start-up, or at once while idle
    apply      = pend && (!en || !run || period_end);
    start      = en && (!run || period_end);
    eff_n      = apply ? n_p   : n_a;
    eff_num    = apply ? num_p : num_a;
    eff_den    = apply ? den_p : den_a;
    eff_acc    = apply ? AW'(0) : acc;
    sum        = eff_acc + {1'b0, eff_num};
    take       = (sum >= {1'b0, eff_den});
    new_len    = {1'b0, eff_n} + CW'(take);
    cnt_inc    = cnt + CW'(1);
  end

  // configuration registers: capture into pending, promote to active on apply
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_a   <= INT_W'(DEF_INT);
      num_a <= FRAC_W'(DEF_NUM);
      den_a <= FRAC_W'(DEF_DEN);
      n_p   <= INT_W'(DEF_INT);
      num_p <= FRAC_W'(DEF_NUM);
      den_p <= FRAC_W'(DEF_DEN);
      pend  <= 1'b0;
    end else begin
      if (apply) begin
        n_a   <= n_p;
        num_a <= num_p;
        den_a <= den_p;
      end
      // a load coinciding with apply lands in pending for the next boundary
      if (cfg_load) begin
        n_p   <= s_int;
        num_p <= s_num;
        den_p <= s_den;
        pend  <= 1'b1;
      end else if (apply) begin
        pend  <= 1'b0;
      end
    end
  end

  // period counter, accumulator and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      cnt       <= '0;
      len       <= CW'(DEF_INT);
      acc       <= '0;
      pulse_out <= 1'b0;
      clk_out   <= 1'b0;
    end else if (!en) begin
      // disabled: drop any partial period without a pulse
      run       <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      pulse_out <= 1'b0;
      clk_out   <= 1'b0;
    end else if (start) begin
      // first cycle of a period; len >= 2 so clk_out always opens high
      run       <= 1'b1;
      cnt       <= '0;
      len       <= new_len;
      acc       <= take ? (sum - {1'b0, eff_den}) : sum;
      pulse_out <= 1'b0;
      clk_out   <= 1'b1;
    end else begin
      cnt       <= cnt_inc;
      pulse_out <= (cnt_inc == len - CW'(1));
      clk_out   <= (cnt_inc < (len >> 1));
    end
  end

  assign cfg_pend = pend;

endmodule

// File: tb/tb_frac_clk_div.sv
// Bench for frac_clk_div: driver steps a period-level reference model once per
// clock and queues the expected outputs; a monitor pops and compares each cycle.
module tb_frac_clk_div;

  logic       clk, rst_n, en, cfg_load;
  logic [7:0] div_int;
  logic [3:0] frac_num, frac_den;
  logic       pulse_out, clk_out, cfg_pend;

  frac_clk_div #(.INT_W(8), .FRAC_W(4), .DEF_INT(8), .DEF_NUM(7), .DEF_DEN(10)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_load(cfg_load),
    .div_int(div_int), .frac_num(frac_num), .frac_den(frac_den),
    .pulse_out(pulse_out), .clk_out(clk_out), .cfg_pend(cfg_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic p; logic c; logic q; } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  // reference model: period k of a config has length N + floor((k+1)num/den) - floor(k num/den)
  int m_n, m_num, m_den, m_pn, m_pnum, m_pden;
  bit m_pend, m_run;
  int m_pos, m_k;

  function automatic int cur_len();
    return m_n + ((m_k + 1) * m_num) / m_den - (m_k * m_num) / m_den;
  endfunction

  task automatic mreset();
    m_n = 8; m_num = 7; m_den = 10;
    m_pn = 8; m_pnum = 7; m_pden = 10;
    m_pend = 0; m_run = 0; m_pos = 0; m_k = 0;
  endtask

  task automatic chk(input string name, input logic act, input logic req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // one clock of stimulus plus the model's view of the following cycle
  task automatic step(input bit e, input bit ld = 0, input int n = 0,
                      input int nu = 0, input int de = 0, input bit r = 1);
    exp_t x;
    int cl;
    bit cur_end, apply;
    @(negedge clk);
    rst_n = r; en = e; cfg_load = ld;
    div_int = 8'(n); frac_num = 4'(nu); frac_den = 4'(de);
    if (!r) begin
      mreset();
      x.p = 0; x.c = 0; x.q = 0;
    end else begin
      cl = m_run ? cur_len() : 0;
      cur_end = m_run && (m_pos == cl - 1);
      apply = m_pend && (!e || !m_run || cur_end);
      if (!e) begin
        m_run = 0; m_pos = 0;
        if (apply) begin m_n = m_pn; m_num = m_pnum; m_den = m_pden; end
      end else if (!m_run || cur_end) begin
        if (apply) begin m_n = m_pn; m_num = m_pnum; m_den = m_pden; m_k = 0; end
        else if (!m_run) m_k = 0;
        else m_k = (m_k + 1) % m_den;
        m_pos = 0; m_run = 1;
      end else begin
        m_pos++;
      end
      if (ld) begin
        m_pn = (n < 2) ? 2 : n;
        if (de == 0 || nu >= de) begin m_pnum = 0; m_pden = 1; end
        else begin m_pnum = nu; m_pden = de; end
        m_pend = 1;
      end else if (apply) begin
        m_pend = 0;
      end
      x.p = m_run && (m_pos == cur_len() - 1);
      x.c = m_run && (m_pos < cur_len() / 2);
      x.q = m_pend;
    end
    sb.push_back(x);
  endtask

  // monitor: compare every cycle the driver has predicted
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        ex = sb.pop_front();
        chk("pulse_out", pulse_out, ex.p);
        chk("clk_out",   clk_out,   ex.c);
        chk("cfg_pend",  cfg_pend,  ex.q);
      end
    end
  end

  initial begin
    int guard;
    rst_n = 0; en = 0; cfg_load = 0; div_int = 0; frac_num = 0; frac_den = 0;
    mreset();
    // reset state, then idle with reset released
    repeat (3) step(0, 0, 0, 0, 0, 0);
    repeat (3) step(0);

    // defaults 8 + 7/10
    repeat (180) step(1);

    // integer ratio 5 applied at next boundary
    step(1, 1, 5, 0, 3);
    repeat (40) step(1);

    // illegal config -> N=2 integer
    step(1, 1, 1, 4, 4);
    repeat (20) step(1);

    // back to 8.7, then load N=4 exactly in a period-end cycle
    step(1, 1, 8, 7, 10);
    guard = 0;
    while (!(m_run && m_pos == cur_len() - 1) && guard < 40) begin step(1); guard++; end
    step(1, 1, 4, 0, 1);
    repeat (40) step(1);

    // return to defaults, then drop enable at cnt == 3
    step(1, 1, 8, 7, 10);
    repeat (30) step(1);
    guard = 0;
    while (!(m_run && m_pos == 3) && guard < 40) begin step(1); guard++; end
    repeat (4) step(0);
    repeat (60) step(1);

    // randomised enable and reconfiguration, including illegal values
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 24) == 0)
        step($urandom_range(0, 19) != 0, 1, $urandom_range(0, 12),
             $urandom_range(0, 15), $urandom_range(0, 15));
      else
        step($urandom_range(0, 19) != 0);
    end

    // mid-period asynchronous reset with a pending config outstanding
    step(1, 1, 12, 3, 7);
    guard = 0;
    while (!(m_run && m_pos == 2 && cur_len() >= 6) && guard < 60) begin step(1); guard++; end
    step(1, 0, 0, 0, 0, 0);
    #1;
    chk("async_pulse", pulse_out, 1'b0);
    chk("async_clk",   clk_out,   1'b0);
    chk("async_pend",  cfg_pend,  1'b0);
    repeat (2) step(1, 0, 0, 0, 0, 0);
    repeat (100) step(1);

    // drain the scoreboard
    guard = 0;
    while (sb.size() != 0 && guard < 10) begin @(posedge clk); guard++; end
    #2;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
